// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: chip identifiers, widths and dump controller encodings shared by the ROM dump slice.
package rom_reader_pkg;
  localparam int IP3604 = 1;
  localparam int IP3601 = 2;
  localparam int IP3604_DATA_WIDTH = 8;
  localparam int IP3604_ADDRESS_WIDTH = 9;
  localparam int IP3601_DATA_WIDTH = 4;
  localparam int IP3601_ADDRESS_WIDTH = 8;
  localparam int RECORD_BYTES = 3;
  typedef enum logic [2:0] {IDLE, RST_RDR, SETTLE, CHECK, SEND, INC_HI, FINISH} dump_state_t;
  typedef enum logic [1:0] {SEND_HI, SEND_LO, SEND_DAT} byte_sel_t;
endpackage

// File: rtl/rom_dump_controller_if.sv
// rom_dump_controller_if: valid/ready byte stream from the dump controller towards the UART transmitter.
interface rom_dump_controller_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, output tx_valid, input tx_ready);
  modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/rom_dump_controller_record_tx.sv
// rom_record_tx: latches one {address, data} word and emits it as three bytes over valid/ready.
module rom_record_tx
  import rom_reader_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic abort,
  input logic load,
  input logic [15:0] address,
  input logic [7:0] data,
  rom_dump_controller_if.master tx,
  output logic record_done
);
  logic [15:0] rec;
  byte_sel_t sel;
  assign record_done = tx.tx_valid && tx.tx_ready && sel == SEND_DAT;
  // The high address byte is presented straight from the load inputs; only the rest needs holding.
  always_ff @(posedge clk)
    if (reset || abort) begin
      tx.tx_valid <= 1'b0;
      tx.tx_data <= 8'h00;
      sel <= SEND_HI;
      rec <= 16'h0000;
    end else if (load) begin
      rec <= {address[7:0], data};
      tx.tx_data <= address[15:8];
      tx.tx_valid <= 1'b1;
      sel <= SEND_HI;
    end else if (tx.tx_valid && tx.tx_ready) begin
      tx.tx_valid <= sel != SEND_DAT;
      tx.tx_data <= sel == SEND_HI ? rec[15:8] : sel == SEND_LO ? rec[7:0] : tx.tx_data;
      sel <= sel == SEND_HI ? SEND_LO : SEND_DAT;
    end
endmodule

// File: rtl/rom_dump_controller.sv
// rom_dump_controller: walks rom_reader through every word and streams a 3-byte record per word.
module rom_dump_controller
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SETTLE_CYCLES = 16,
  parameter int PULSE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic abort,
  input logic [ADDRESS_WIDTH-1:0] address_line,
  input logic [DATA_WIDTH-1:0] data_line,
  output logic rom_reset_n,
  output logic increment_address,
  output logic decrement_address,
  rom_dump_controller_if.master tx,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int CW = $clog2(SETTLE_CYCLES + PULSE_CYCLES + 2);
  dump_state_t state;
  logic [ADDRESS_WIDTH:0] index;
  logic [CW-1:0] cnt;
  logic match, last, load, record_done;
  assign match = address_line == index[ADDRESS_WIDTH-1:0];
  assign last = &index[ADDRESS_WIDTH-1:0];
  assign load = state == CHECK && match;
  assign decrement_address = 1'b0;
  rom_record_tx u_tx (
    .clk(clk),
    .reset(reset),
    .abort(abort),
    .load(load),
    .address(16'(address_line)),
    .data(8'(data_line)),
    .tx(tx),
    .record_done(record_done)
  );
  always_ff @(posedge clk)
    if (reset || abort) begin
      state <= IDLE;
      rom_reset_n <= 1'b1;
      increment_address <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      if (reset) begin
        error <= 1'b0;
        index <= '0;
      end
    end else
      case (state)
        // FINISH behaves like IDLE so a start coinciding with done begins the next dump at once.
        IDLE, FINISH: begin
          done <= 1'b0;
          state <= start ? RST_RDR : IDLE;
          if (start) begin
            rom_reset_n <= 1'b0;
            busy <= 1'b1;
            error <= 1'b0;
            index <= '0;
            cnt <= '0;
          end
        end
        RST_RDR:
          if (cnt == CW'(1)) begin
            rom_reset_n <= 1'b1;
            cnt <= '0;
            state <= SETTLE;
          end else cnt <= cnt + 1'b1;
        SETTLE:
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt <= '0;
            state <= CHECK;
          end else cnt <= cnt + 1'b1;
        CHECK:
          if (match) state <= SEND;
          else begin
            error <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        SEND:
          if (record_done) begin
            state <= last ? FINISH : INC_HI;
            done <= last;
            busy <= !last;
            increment_address <= !last;
          end
        INC_HI:
          if (cnt == CW'(PULSE_CYCLES - 1)) begin
            increment_address <= 1'b0;
            index <= index + 1'b1;
            cnt <= '0;
            state <= SETTLE;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_rom_dump_controller.sv
// tb_rom_dump_controller: two controllers (3604-like tiny ROM and 3601-like 4-bit ROM) against behavioural readers.
module tb_rom_dump_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic start_a = 0, abort_a = 0, rst_n_a, inc_a, dec_a, busy_a, done_a, err_a;
  logic [1:0] addr_a;
  logic [7:0] data_a;
  logic start_b = 0, abort_b = 0, rst_n_b, inc_b, dec_b, busy_b, done_b, err_b;
  logic [7:0] addr_b;
  logic [3:0] data_b;
  rom_dump_controller_if ifa ();
  rom_dump_controller_if ifb ();
  rom_dump_controller #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .address_line(addr_a), .data_line(data_a),
    .rom_reset_n(rst_n_a), .increment_address(inc_a), .decrement_address(dec_a), .tx(ifa),
    .busy(busy_a), .done(done_a), .error(err_a));
  rom_dump_controller #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .address_line(addr_b), .data_line(data_b),
    .rom_reset_n(rst_n_b), .increment_address(inc_b), .decrement_address(dec_b), .tx(ifb),
    .busy(busy_b), .done(done_b), .error(err_b));
  // behavioural rom_readers: counter steps two clocks after increment_address is released
  logic [7:0] rom_a [4];
  logic [3:0] rom_b [256];
  logic q_a = 0, fell_a = 0, stuck_a = 0, q_b = 0, fell_b = 0;
  always @(posedge clk) begin
    q_a <= inc_a;
    fell_a <= q_a && !inc_a;
    if (!rst_n_a) begin
      addr_a <= 2'd0;
      fell_a <= 1'b0;
    end else if (fell_a && !(stuck_a && addr_a == 2'd1)) addr_a <= addr_a + 2'd1;
    q_b <= inc_b;
    fell_b <= q_b && !inc_b;
    if (!rst_n_b) begin
      addr_b <= 8'd0;
      fell_b <= 1'b0;
    end else if (fell_b) addr_b <= addr_b + 8'd1;
  end
  assign data_a = rom_a[addr_a];
  assign data_b = rom_b[addr_b];
  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int ndone_a = 0, nrst_a = 0, viol_a = 0, ndone_b = 0;
  logic hold_a = 0;
  logic [7:0] hdata_a = 0;
  always @(negedge clk) begin
    if (ifa.tx_valid && ifa.tx_ready) got_a.push_back(ifa.tx_data);
    if (ifb.tx_valid && ifb.tx_ready) got_b.push_back(ifb.tx_data);
    if (hold_a && (!ifa.tx_valid || ifa.tx_data != hdata_a)) viol_a <= viol_a + 1;
    hold_a <= ifa.tx_valid && !ifa.tx_ready;
    hdata_a <= ifa.tx_data;
    if (done_a) ndone_a <= ndone_a + 1;
    if (done_b) ndone_b <= ndone_b + 1;
    if (!rst_n_a) nrst_a <= nrst_a + 1;
  end
  // reference: record i is {i[15:8], i[7:0], rom[i]}
  task automatic build_exp_a();
    exp_a.delete();
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(8'((i >> 8) & 255));
      exp_a.push_back(8'(i & 255));
      exp_a.push_back(rom_a[i]);
    end
  endtask
  task automatic build_exp_b();
    exp_b.delete();
    for (int i = 0; i < 256; i++) begin
      exp_b.push_back(8'((i >> 8) & 255));
      exp_b.push_back(8'(i & 255));
      exp_b.push_back({4'h0, rom_b[i]});
    end
  endtask
  task automatic test_reset();
    ifa.tx_ready = 1'b1;
    ifb.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rst_n_a, inc_a, dec_a, ifa.tx_valid, busy_a, done_a, err_a, ifa.tx_data} !== {7'b1000000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_a: got %b required %b", {rst_n_a, inc_a, dec_a, ifa.tx_valid, busy_a, done_a, err_a, ifa.tx_data}, {7'b1000000, 8'h00});
    end
    vectors++;
    if ({rst_n_b, inc_b, dec_b, ifb.tx_valid, busy_b, done_b, err_b, ifb.tx_data} !== {7'b1000000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_b: got %b required %b", {rst_n_b, inc_b, dec_b, ifb.tx_valid, busy_b, done_b, err_b, ifb.tx_data}, {7'b1000000, 8'h00});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask
  task automatic test_dump_a(input bit rand_ready);
    int base, d0, r0, v0, n;
    logic [2:0] lat;
    build_exp_a();
    base = got_a.size(); d0 = ndone_a; r0 = nrst_a; v0 = viol_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk); lat[2] = rst_n_a;
    @(negedge clk); lat[1] = rst_n_a;
    @(negedge clk); lat[0] = rst_n_a;
    vectors++;
    if (lat !== 3'b001) begin
      miscompares++;
      $display("FAIL dump_a_latency: rom_reset_n got %b required 001", lat);
    end
    n = 0;
    while (ndone_a == d0 && !err_a && n < 2000) begin
      @(posedge clk); #1 if (rand_ready) ifa.tx_ready = 1'($urandom_range(1));
      @(negedge clk); n++;
    end
    @(posedge clk); #1 ifa.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (n >= 2000) begin miscompares++; $display("FAIL dump_a_timeout: waited %0d cycles", n); end
    vectors++;
    if (got_a.size() - base !== 12) begin
      miscompares++;
      $display("FAIL dump_a_count: got %0d bytes required 12", got_a.size() - base);
    end
    for (int k = 0; k < 12 && base + k < got_a.size(); k++) begin
      vectors++;
      if (got_a[base+k] !== exp_a[k]) begin
        miscompares++;
        $display("FAIL dump_a_byte%0d: got %h required %h", k, got_a[base+k], exp_a[k]);
      end
    end
    vectors++;
    if ({ndone_a - d0, nrst_a - r0, viol_a - v0} !== {32'd1, 32'd2, 32'd0}) begin
      miscompares++;
      $display("FAIL dump_a_events: done %0d reset_cycles %0d unstable %0d required 1 2 0", ndone_a - d0, nrst_a - r0, viol_a - v0);
    end
    vectors++;
    if ({err_a, busy_a} !== 2'b00) begin
      miscompares++;
      $display("FAIL dump_a_flags: error/busy got %b required 00", {err_a, busy_a});
    end
  endtask
  task automatic test_stuck_a();
    int base, d0, n;
    stuck_a = 1'b1;
    build_exp_a();
    base = got_a.size(); d0 = ndone_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (!err_a && ndone_a == d0 && n < 2000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    vectors++;
    if ({err_a, busy_a} !== 2'b10 || n >= 2000) begin
      miscompares++;
      $display("FAIL stuck_flags: error/busy got %b required 10 after %0d cycles", {err_a, busy_a}, n);
    end
    vectors++;
    if (got_a.size() - base !== 6 || ndone_a != d0) begin
      miscompares++;
      $display("FAIL stuck_count: got %0d bytes %0d done required 6 bytes 0 done", got_a.size() - base, ndone_a - d0);
    end
    for (int k = 0; k < 6 && base + k < got_a.size(); k++) begin
      vectors++;
      if (got_a[base+k] !== exp_a[k]) begin
        miscompares++;
        $display("FAIL stuck_byte%0d: got %h required %h", k, got_a[base+k], exp_a[k]);
      end
    end
    stuck_a = 1'b0;
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    @(negedge clk);
    vectors++;
    if (err_a !== 1'b1) begin miscompares++; $display("FAIL abort_keeps_error: got %b required 1", err_a); end
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    vectors++;
    if ({err_a, busy_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL start_clears_error: error/busy got %b required 01", {err_a, busy_a});
    end
    @(posedge clk); #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_start_held_a();
    int base, r0, n;
    build_exp_a();
    base = got_a.size(); r0 = nrst_a;
    @(posedge clk); #1 start_a = 1'b1;
    n = 0;
    while (!done_a && n < 2000) begin @(negedge clk); n++; end
    vectors++;
    if (busy_a !== 1'b0 || n >= 2000) begin
      miscompares++;
      $display("FAIL held_done: busy got %b at done after %0d cycles required 0", busy_a, n);
    end
    vectors++;
    if (nrst_a - r0 !== 2 || got_a.size() - base !== 12) begin
      miscompares++;
      $display("FAIL held_single_dump: reset_cycles %0d bytes %0d required 2 and 12", nrst_a - r0, got_a.size() - base);
    end
    @(negedge clk);
    vectors++;
    if ({rst_n_a, busy_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL held_restart: rom_reset_n/busy got %b required 01", {rst_n_a, busy_a});
    end
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy_a, rst_n_a, ifa.tx_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL start_abort_same_cycle: busy/rom_reset_n/tx_valid got %b required 010", {busy_a, rst_n_a, ifa.tx_valid});
    end
  endtask
  task automatic run_b(input string name);
    int base, d0, n;
    logic [2:0] lat;
    build_exp_b();
    base = got_b.size(); d0 = ndone_b;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk); lat[2] = rst_n_b;
    @(negedge clk); lat[1] = rst_n_b;
    @(negedge clk); lat[0] = rst_n_b;
    vectors++;
    if (lat !== 3'b001) begin miscompares++; $display("FAIL %s_latency: rom_reset_n got %b required 001", name, lat); end
    n = 0;
    while (ndone_b == d0 && !err_b && n < 20000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (got_b.size() - base !== 768 || n >= 20000 || err_b !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes error %b after %0d cycles required 768 bytes error 0", name, got_b.size() - base, err_b, n);
    end
    for (int k = 0; k < 768 && base + k < got_b.size(); k++) begin
      vectors++;
      if (got_b[base+k] !== exp_b[k]) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got %h required %h", name, k, got_b[base+k], exp_b[k]);
      end
    end
    if (base + 497 < got_b.size()) begin
      vectors++;
      if ({got_b[base+495], got_b[base+496], got_b[base+497]} !== 24'h00A507) begin
        miscompares++;
        $display("FAIL %s_record_a5: got %h required 00a507", name, {got_b[base+495], got_b[base+496], got_b[base+497]});
      end
    end
  endtask
  task automatic test_narrow_b();
    for (int i = 0; i < 256; i++) rom_b[i] = 4'($urandom);
    rom_b[8'hA5] = 4'h7;
    run_b("narrow");
  endtask
  task automatic test_abort_b();
    int base, n;
    base = got_b.size();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      if (got_b.size() - base >= 16) break;
      n++;
    end
    ifb.tx_ready = 1'b0;
    abort_b = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ifb.tx_valid, ifb.tx_data} !== 9'h105 || n >= 5000) begin
      miscompares++;
      $display("FAIL abort_in_send_lo: valid/data got %h required 105 after %0d cycles", {ifb.tx_valid, ifb.tx_data}, n);
    end
    @(posedge clk); #1 abort_b = 1'b0; ifb.tx_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ifb.tx_valid, busy_b, inc_b, rst_n_b, done_b} !== 5'b00010) begin
      miscompares++;
      $display("FAIL abort_outputs: valid/busy/inc/rom_reset_n/done got %b required 00010", {ifb.tx_valid, busy_b, inc_b, rst_n_b, done_b});
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (got_b.size() - base !== 16) begin
      miscompares++;
      $display("FAIL abort_truncates: got %0d bytes required 16", got_b.size() - base);
    end
    run_b("restart");
  endtask
  initial begin
    rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;
    test_reset();
    test_dump_a(1'b0);
    test_dump_a(1'b1);
    for (int i = 0; i < 4; i++) rom_a[i] = 8'($urandom);
    test_dump_a(1'b1);
    test_stuck_a();
    test_start_held_a();
    test_narrow_b();
    test_abort_b();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
